// File: rtl/seg_scan_if.sv
// Load channel for seg_scan_ctrl: a requester offers a complete display image
// (eight hex nibbles, per-digit enables and decimal points) through a
// valid/ready handshake.
interface seg_scan_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_hex;
    logic [7:0]  ld_den;
    logic [7:0]  ld_dp;

    // Requester side: drives the image and valid, watches ready.
    modport master (
        output ld_valid,
        output ld_hex,
        output ld_den,
        output ld_dp,
        input  ld_ready
    );

    // Scan controller side: samples the image, reports whether it can take one.
    modport slave (
        input  ld_valid,
        input  ld_hex,
        input  ld_den,
        input  ld_dp,
        output ld_ready
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller.
//
// Each digit owns a fixed slot: a BLANK guard (all cathodes and anodes off,
// prevents ghosting while the anode switches) followed by SHOW. Eight slots
// make a frame. A new image is parked in a single pending buffer and only
// moved into the displayed registers on the frame wrap, so a frame never mixes
// two images. Disabled digits keep their slot so the frame rate is constant.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_BLANK | anodes and cathodes all off for BLANK_CYC cycles
//   ST_SHOW  | digit idx driven for SHOW_CYC cycles (anode gated by den)
//
// Before the first clock edge after reset the controller sits in ST_BLANK
// with the counter at zero; that first edge arms the scan and begins the
// idx 0 BLANK period.
module seg_scan_ctrl #(
    parameter int SHOW_CYC  = 100000,
    parameter int BLANK_CYC = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    seg_scan_if.slave   ld,
    output logic [7:0]  segments,
    output logic [7:0]  an,
    output logic        frame_start
);

    localparam int MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // The counter holds "cycles remaining minus one", so it reloads with N-1
    // and the state ends on the cycle where it reads zero.
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic [2:0]     idx_q;
    logic [2:0]     idx_d;
    logic           run_q;

    // Displayed image; only ever rewritten on the frame wrap.
    logic [31:0]    hex_q;
    logic [7:0]     den_q;
    logic [7:0]     dp_q;

    // Single-entry pending image waiting for the next wrap.
    logic [31:0]    pend_hex;
    logic [7:0]     pend_den;
    logic [7:0]     pend_dp;
    logic           pend_full;

    logic           wrap;
    logic           take;
    logic [7:0]     seg_d;
    logic [7:0]     an_d;
    logic [3:0]     cur_nib;

    // Lit-segment pattern {g,f,e,d,c,b,a}, active-high; inverted at the pins.
    function automatic logic [6:0] seg_lit(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0:    p = 7'b0111111;
            4'h1:    p = 7'b0000110;
            4'h2:    p = 7'b1011011;
            4'h3:    p = 7'b1001111;
            4'h4:    p = 7'b1100110;
            4'h5:    p = 7'b1101101;
            4'h6:    p = 7'b1111101;
            4'h7:    p = 7'b0000111;
            4'h8:    p = 7'b1111111;
            4'h9:    p = 7'b1101111;
            4'hA:    p = 7'b1110111;
            4'hB:    p = 7'b1111100;
            4'hC:    p = 7'b1011000;
            4'hD:    p = 7'b1011110;
            4'hE:    p = 7'b1111001;
            default: p = 7'b1110001;
        endcase
        return p;
    endfunction

    // A load is accepted whenever the pending buffer is empty; valid while
    // full is simply not acknowledged and the scan carries on regardless.
    assign ld.ld_ready = ~pend_full;
    assign take        = ld.ld_valid & ~pend_full;

    assign cur_nib = hex_q[{idx_q, 2'b00} +: 4];

    // Next-state, slot timing and the output values registered on each
    // state change; outputs hold their value for the whole of a state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wrap    = 1'b0;
        seg_d   = segments;
        an_d    = an;

        if (!run_q) begin
            // First edge out of reset: start timing the idx 0 BLANK.
            cnt_d = BLANK_LAST;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else if (state_q == ST_BLANK) begin
            state_d = ST_SHOW;
            cnt_d   = SHOW_LAST;
            seg_d   = {~dp_q[idx_q], ~seg_lit(cur_nib)};
            an_d    = den_q[idx_q] ? ~(8'b1 << idx_q) : 8'hFF;
        end else begin
            state_d = ST_BLANK;
            cnt_d   = BLANK_LAST;
            idx_d   = idx_q + 3'd1;
            wrap    = (idx_q == 3'd7);
            seg_d   = 8'hFF;
            an_d    = 8'hFF;
        end
    end

    // Scan state, slot counter and registered display pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            run_q       <= 1'b0;
            segments    <= 8'hFF;
            an          <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            run_q       <= 1'b1;
            segments    <= seg_d;
            an          <= an_d;
            frame_start <= wrap;
        end
    end

    // Pending buffer fill on handshake, and transfer to the displayed image on
    // the wrap. A load accepted on the wrap edge itself (buffer was empty)
    // stays pending and is shown from the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_q     <= '0;
            den_q     <= '0;
            dp_q      <= '0;
            pend_hex  <= '0;
            pend_den  <= '0;
            pend_dp   <= '0;
            pend_full <= 1'b0;
        end else begin
            if (wrap && pend_full) begin
                hex_q <= pend_hex;
                den_q <= pend_den;
                dp_q  <= pend_dp;
            end
            if (take) begin
                pend_hex  <= ld.ld_hex;
                pend_den  <= ld.ld_den;
                pend_dp   <= ld.ld_dp;
                pend_full <= 1'b1;
            end else if (wrap) begin
                pend_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SHOW_CYC=4, BLANK_CYC=2 (slot 6
// cycles, frame 48). "cyc" is the number of rising edges since reset release;
// all sampling and driving happens on the falling edge that follows.
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] segments;
    logic [7:0] an;
    logic       frame_start;

    seg_scan_if bus ();

    seg_scan_ctrl #(
        .SHOW_CYC  (4),
        .BLANK_CYC (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld          (bus),
        .segments    (segments),
        .an          (an),
        .frame_start (frame_start)
    );

    // Active-low cathode codes {dp,g..a} with dp off, hand-derived from the
    // lit-segment table.
    logic [7:0] seg_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E
    };

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int c0;

    // Image the bench expects on the display in the current frame.
    logic [31:0] disp_hex;
    logic [7:0]  disp_den;
    logic [7:0]  disp_dp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // Expected pins for cycle cyc from its slot position and the displayed image.
    task automatic check_cycle();
        int p, slot, q;
        logic [7:0] ea, es;
        logic [3:0] nib;
        p    = (cyc - 1) % 48;
        slot = p / 6;
        q    = p % 6;
        if (q < 2) begin
            ea = 8'hFF;
            es = 8'hFF;
        end else begin
            nib = 4'(disp_hex >> (slot * 4));
            es  = seg_tab[nib];
            if (disp_dp[slot]) es[7] = 1'b0;
            ea  = disp_den[slot] ? ~(8'h01 << slot) : 8'hFF;
        end
        chk8("an", an, ea);
        chk8("segments", segments, es);
        chk1("frame_start", frame_start, (p == 0) && (cyc > 48));
    endtask

    task automatic run_to(input int k);
        while (cyc < k) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            check_cycle();
        end
    endtask

    task automatic offer(input logic [31:0] h, input logic [7:0] d, input logic [7:0] p);
        bus.ld_valid = 1'b1;
        bus.ld_hex   = h;
        bus.ld_den   = d;
        bus.ld_dp    = p;
    endtask

    task automatic set_disp(input logic [31:0] h, input logic [7:0] d, input logic [7:0] p);
        disp_hex = h;
        disp_den = d;
        disp_dp  = p;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_hex   = '0;
        bus.ld_den   = '0;
        bus.ld_dp    = '0;
        set_disp(32'h0, 8'h00, 8'h00);

        // Reset state.
        @(negedge clk);
        chk8("rst_segments", segments, 8'hFF);
        chk8("rst_an", an, 8'hFF);
        chk1("rst_frame_start", frame_start, 1'b0);
        chk1("rst_ld_ready", bus.ld_ready, 1'b1);

        // Digit 0 shows "1"; nothing lit during the first frame.
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        offer(32'h0000_0001, 8'h01, 8'h00);
        run_to(1);
        bus.ld_valid = 1'b0;
        chk1("ready_after_load", bus.ld_ready, 1'b0);
        run_to(48);
        chk1("ready_held_frame0", bus.ld_ready, 1'b0);
        set_disp(32'h0000_0001, 8'h01, 8'h00);
        run_to(49);
        chk1("ready_after_wrap", bus.ld_ready, 1'b1);
        run_to(51);
        chk8("d0_show_an", an, 8'hFE);
        chk8("d0_show_seg", segments, 8'hF9);
        run_to(96);

        // Digit 7 "F" with dp; accepted on the wrap edge so shown one frame later.
        offer(32'hF000_0000, 8'h80, 8'h80);
        run_to(97);
        bus.ld_valid = 1'b0;
        chk1("ready_load_on_wrap", bus.ld_ready, 1'b0);
        run_to(144);
        set_disp(32'hF000_0000, 8'h80, 8'h80);
        run_to(189);
        chk8("d7_show_an", an, 8'h7F);
        chk8("d7_show_seg", segments, 8'h0E);
        run_to(192);

        // Image A, then B mid-frame (held), then C while not ready (dropped).
        offer(32'h7654_3210, 8'hFF, 8'h05);
        run_to(193);
        bus.ld_valid = 1'b0;
        run_to(240);
        set_disp(32'h7654_3210, 8'hFF, 8'h05);
        run_to(260);
        offer(32'hFEDC_BA98, 8'h5A, 8'hA0);
        run_to(261);
        bus.ld_valid = 1'b0;
        chk1("ready_b_pending", bus.ld_ready, 1'b0);
        run_to(270);
        offer(32'h1111_1111, 8'hFF, 8'hFF);
        run_to(280);
        chk1("ready_c_ignored", bus.ld_ready, 1'b0);
        bus.ld_valid = 1'b0;
        run_to(288);
        set_disp(32'hFEDC_BA98, 8'h5A, 8'hA0);
        run_to(289);
        chk1("ready_b_applied", bus.ld_ready, 1'b1);
        run_to(336);

        // Pending image D, then reset mid-SHOW of lit digit 1.
        run_to(338);
        offer(32'h8888_8888, 8'hFF, 8'hFF);
        run_to(339);
        bus.ld_valid = 1'b0;
        run_to(346);
        chk8("d1_lit_an", an, 8'hFD);
        chk8("d1_lit_seg", segments, 8'h90);
        #2;
        rst_n = 1'b0;
        #1;
        chk8("midrst_segments", segments, 8'hFF);
        chk8("midrst_an", an, 8'hFF);
        chk1("midrst_ld_ready", bus.ld_ready, 1'b1);
        chk1("midrst_frame_start", frame_start, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        set_disp(32'h0, 8'h00, 8'h00);

        // All digits disabled; D must never appear, frame_start every 48.
        offer(32'h1234_5678, 8'h00, 8'hFF);
        run_to(1);
        bus.ld_valid = 1'b0;
        run_to(48);
        set_disp(32'h1234_5678, 8'h00, 8'hFF);
        run_to(96);

        // Sweep 0..F on digit 3.
        c0 = 96;
        for (int v = 0; v < 16; v++) begin
            run_to(c0 + 22);
            offer(32'(v) << 12, 8'h08, 8'h00);
            run_to(c0 + 23);
            bus.ld_valid = 1'b0;
            run_to(c0 + 48);
            set_disp(32'(v) << 12, 8'h08, 8'h00);
            c0 = c0 + 48;
            run_to(c0 + 19);
            chk8("sweep_blank_an", an, 8'hFF);
            run_to(c0 + 21);
            chk8("sweep_an", an, 8'hF7);
            chk8("sweep_seg", segments, seg_tab[v]);
        end
        run_to(c0 + 48);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
